// File: rtl/fare_setter.sv
// fare_setter: operator-entry front end for the taxi meter.
// Debounces the push-buttons and runs an IDLE/EDIT state machine. The
// operator edits BCD start/unit prices one digit at a time in shadow
// registers, and the edits reach s_fee/g_fee only on commit.
// Optional feature macro: FARE_SET_DEC_EN adds btn_dec (digit decrement).
module fare_setter #(
   parameter int unsigned DEBOUNCE_CYCLES = 20000,
   parameter int unsigned TIMEOUT_CYCLES  = 50000000,
   parameter logic [15:0] S_FEE_INIT      = 16'h0008,
   parameter logic [15:0] G_FEE_INIT      = 16'h0002
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_mode,
   input  logic        btn_next,
   input  logic        btn_inc,
`ifdef FARE_SET_DEC_EN
   input  logic        btn_dec,
`endif
   output logic [15:0] s_fee,
   output logic [15:0] g_fee,
   output logic        d_m,
   output logic        edit_active,
   output logic [2:0]  cur_digit,
   output logic        fare_valid
);

`ifdef FARE_SET_DEC_EN
   localparam int unsigned NB = 4;
`else
   localparam int unsigned NB = 3;
`endif
   localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned B_MODE = 0;
   localparam int unsigned B_NEXT = 1;
   localparam int unsigned B_INC  = 2;

   typedef enum logic {IDLE, EDIT} state_t;

   logic [NB-1:0] raw;
   logic [NB-1:0] sync0;
   logic [NB-1:0] sync1;
   logic [NB-1:0] level;
   logic [NB-1:0] level_q;
   logic [DW-1:0] cnt [NB];
   logic [NB-1:0] press;

   logic act_mode;
   logic act_next;
   logic act_inc;
`ifdef FARE_SET_DEC_EN
   logic act_dec;
`endif

   state_t        state;
   state_t        state_next;
   logic [31:0]   shadow;
   logic [31:0]   shadow_next;
   logic [2:0]    digit_next;
   logic [TW-1:0] tmo_cnt;
   logic [TW-1:0] tmo_next;
   logic [15:0]   s_next;
   logic [15:0]   g_next;
   logic          fv_next;
   logic          dm_next;
   logic          ea_next;
   logic [4:0]    nib_lsb;
   logic [3:0]    nib;

`ifdef FARE_SET_DEC_EN
   assign raw = {btn_dec, btn_inc, btn_next, btn_mode};
`else
   assign raw = {btn_inc, btn_next, btn_mode};
`endif

   // BCD digit increment, wrapping 9->0; illegal codes clear to 0
   function automatic logic [3:0] inc_bcd(input logic [3:0] n);
      return (n < 4'd9) ? n + 4'd1 : 4'd0;
   endfunction

`ifdef FARE_SET_DEC_EN
   // BCD digit decrement, wrapping 0->9; illegal codes clear to 0
   function automatic logic [3:0] dec_bcd(input logic [3:0] n);
      if (n == 4'd0)
         return 4'd9;
      else if (n <= 4'd9)
         return n - 4'd1;
      else
         return 4'd0;
   endfunction
`endif

   // Synchronize each button, then accept a level after it is stable long enough
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0   <= '0;
         sync1   <= '0;
         level   <= '0;
         level_q <= '0;
         for (int i = 0; i < int'(NB); i++) cnt[i] <= '0;
      end else begin
         sync0   <= raw;
         sync1   <= sync0;
         level_q <= level;
         for (int i = 0; i < int'(NB); i++) begin
            if (sync1[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               level[i] <= sync1[i];
               cnt[i]   <= '0;
            end else begin
               cnt[i] <= cnt[i] + DW'(1);
            end
         end
      end
   end

   // Rising edge of the accepted level is a press; mode > next > inc > dec
   always_comb begin
      press    = level & ~level_q;
      act_mode = press[B_MODE];
      act_next = press[B_NEXT] & ~press[B_MODE];
      act_inc  = press[B_INC] & ~press[B_NEXT] & ~press[B_MODE];
`ifdef FARE_SET_DEC_EN
      act_dec  = press[3] & ~press[B_INC] & ~press[B_NEXT] & ~press[B_MODE];
`endif
   end

   // Digit 0 is the most significant nibble of the {s,g} shadow word
   assign nib_lsb = {~cur_digit, 2'b00};
   assign nib     = shadow[nib_lsb +: 4];

   // Next-state and next-output logic for the edit machine
   always_comb begin
      state_next  = state;
      shadow_next = shadow;
      digit_next  = cur_digit;
      tmo_next    = tmo_cnt;
      s_next      = s_fee;
      g_next      = g_fee;
      fv_next     = 1'b0;
      case (state)
         IDLE: begin
            tmo_next = '0;
            if (act_mode) begin
               shadow_next = {s_fee, g_fee};
               digit_next  = 3'd0;
               state_next  = EDIT;
            end
         end
         EDIT: begin
            tmo_next = '0;
            if (act_mode) begin
               s_next     = shadow[31:16];
               g_next     = shadow[15:0];
               fv_next    = 1'b1;
               state_next = IDLE;
            end else if (act_next) begin
               digit_next = cur_digit + 3'd1;
            end else if (act_inc) begin
               shadow_next[nib_lsb +: 4] = inc_bcd(nib);
`ifdef FARE_SET_DEC_EN
            end else if (act_dec) begin
               shadow_next[nib_lsb +: 4] = dec_bcd(nib);
`endif
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state_next = IDLE;
            end else begin
               tmo_next = tmo_cnt + TW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            tmo_next   = '0;
         end
      endcase
      dm_next = (state_next == IDLE);
      ea_next = (state_next == EDIT);
   end

   // State, shadow and registered output update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shadow      <= {S_FEE_INIT, G_FEE_INIT};
         tmo_cnt     <= '0;
         s_fee       <= S_FEE_INIT;
         g_fee       <= G_FEE_INIT;
         d_m         <= 1'b1;
         edit_active <= 1'b0;
         cur_digit   <= 3'd0;
         fare_valid  <= 1'b0;
      end else begin
         state       <= state_next;
         shadow      <= shadow_next;
         tmo_cnt     <= tmo_next;
         s_fee       <= s_next;
         g_fee       <= g_next;
         d_m         <= dm_next;
         edit_active <= ea_next;
         cur_digit   <= digit_next;
         fare_valid  <= fv_next;
      end
   end

endmodule

// File: tb/tb_fare_setter.sv
// Testbench for fare_setter (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64).
// Committed fares are queued when the commit press is issued; a monitor
// pops and compares them whenever fare_valid is seen.
module tb_fare_setter;

   logic        clk;
   logic        rst_n;
   logic        btn_mode;
   logic        btn_next;
   logic        btn_inc;
`ifdef FARE_SET_DEC_EN
   logic        btn_dec;
`endif
   logic [15:0] s_fee;
   logic [15:0] g_fee;
   logic        d_m;
   logic        edit_active;
   logic [2:0]  cur_digit;
   logic        fare_valid;

   int checks;
   int failures;

   typedef struct packed {
      logic [15:0] s;
      logic [15:0] g;
   } fare_t;

   fare_t exp_q[$];
   logic  fv_prev;

   fare_setter #(
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES(64),
      .S_FEE_INIT(16'h0008),
      .G_FEE_INIT(16'h0002)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_mode(btn_mode),
      .btn_next(btn_next),
      .btn_inc(btn_inc),
`ifdef FARE_SET_DEC_EN
      .btn_dec(btn_dec),
`endif
      .s_fee(s_fee),
      .g_fee(g_fee),
      .d_m(d_m),
      .edit_active(edit_active),
      .cur_digit(cur_digit),
      .fare_valid(fare_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_btns(input logic [3:0] m);
      btn_mode = m[0];
      btn_next = m[1];
      btn_inc  = m[2];
`ifdef FARE_SET_DEC_EN
      btn_dec  = m[3];
`endif
   endtask

   // Clean press: 10 cycles held, 10 cycles released
   task automatic press(input logic [3:0] m);
      @(negedge clk);
      set_btns(m);
      repeat (10) @(negedge clk);
      set_btns(4'b0000);
      repeat (10) @(negedge clk);
   endtask

   task automatic press_n(input logic [3:0] m, input int n);
      for (int i = 0; i < n; i++) press(m);
   endtask

   task automatic check_outputs(input string tag, input logic [15:0] s, input logic [15:0] g,
                                input logic dm, input logic ea);
      chk({tag, "_s_fee"}, 32'(s_fee), 32'(s));
      chk({tag, "_g_fee"}, 32'(g_fee), 32'(g));
      chk({tag, "_d_m"}, 32'(d_m), 32'(dm));
      chk({tag, "_edit_active"}, 32'(edit_active), 32'(ea));
   endtask

   // Scoreboard monitor: each fare_valid pulse must match the oldest queued fare
   initial begin
      fv_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (fare_valid) begin
            chk("fare_valid_width", 32'(fv_prev), 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL fare_valid_unexpected: got s=%h g=%h expected no pulse", s_fee, g_fee);
            end else begin
               fare_t e;
               e = exp_q.pop_front();
               if (s_fee !== e.s || g_fee !== e.g) begin
                  failures++;
                  $display("FAIL commit_value: got s=%h g=%h expected s=%h g=%h", s_fee, g_fee, e.s, e.g);
               end
            end
         end
         fv_prev = fare_valid;
      end
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      set_btns(4'b0000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Reset values
      check_outputs("reset", 16'h0008, 16'h0002, 1'b1, 1'b0);
      chk("reset_cur_digit", 32'(cur_digit), 32'd0);
      chk("reset_fare_valid", 32'(fare_valid), 32'd0);

      // 2-cycle glitch must be rejected
      set_btns(4'b0001);
      repeat (2) @(negedge clk);
      set_btns(4'b0000);
      repeat (15) @(negedge clk);
      chk("glitch_edit_active", 32'(edit_active), 32'd0);

      // 10-cycle press enters EDIT within a bounded latency
      set_btns(4'b0001);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (edit_active && lat == 0) lat = k;
      end
      set_btns(4'b0000);
      repeat (10) @(negedge clk);
      chk("enter_latency_ok", 32'(lat >= 5 && lat <= 8), 32'd1);
      check_outputs("edit", 16'h0008, 16'h0002, 1'b0, 1'b1);
      chk("edit_cur_digit", 32'(cur_digit), 32'd0);

      // Full edit: digit0 +3, move to digit7, +9 with wrap and no carry
      press_n(4'b0100, 3);
      chk("inc_keeps_digit", 32'(cur_digit), 32'd0);
      press_n(4'b0010, 7);
      chk("next7_cur_digit", 32'(cur_digit), 32'd7);
      press_n(4'b0100, 9);
      chk("edit_s_fee_held", 32'(s_fee), 32'h0008);
      exp_q.push_back('{s: 16'h3008, g: 16'h0001});
      press(4'b0001);
      check_outputs("commit", 16'h3008, 16'h0001, 1'b1, 1'b0);

      // Timeout abort: no commit, outputs unchanged
      press(4'b0001);
      chk("tmo_enter_edit", 32'(edit_active), 32'd1);
      press_n(4'b0100, 2);
      chk("tmo_still_edit", 32'(edit_active), 32'd1);
      repeat (70) @(negedge clk);
      check_outputs("timeout", 16'h3008, 16'h0001, 1'b1, 1'b0);

      // Simultaneous presses: next beats inc, mode beats inc
      press(4'b0001);
      press(4'b0100);
      press(4'b0110);
      chk("next_inc_cur_digit", 32'(cur_digit), 32'd1);
      exp_q.push_back('{s: 16'h4008, g: 16'h0001});
      press(4'b0101);
      check_outputs("mode_inc", 16'h4008, 16'h0001, 1'b1, 1'b0);

      // Reset mid-edit: outputs return to reset values asynchronously
      press(4'b0001);
      press(4'b0100);
      chk("pre_reset_edit", 32'(edit_active), 32'd1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_outputs("async_reset", 16'h0008, 16'h0002, 1'b1, 1'b0);
      chk("async_reset_cur_digit", 32'(cur_digit), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

`ifdef FARE_SET_DEC_EN
      // Decrement of a zero digit wraps to 9
      press(4'b0001);
      press(4'b0010);
      press(4'b1000);
      exp_q.push_back('{s: 16'h0908, g: 16'h0002});
      press(4'b0001);
      check_outputs("dec", 16'h0908, 16'h0002, 1'b1, 1'b0);
`endif

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
